// File: rtl/audio_pkg.sv
// Shared audio types and helpers for the output end of the effect chain.
// Contents:
//   i2s_state_t    - transmitter FSM state (IDLE, RUN)
//   i2s_frame_clks - clk cycles per I2S frame (two slots of slot_bits bclks)
package audio_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } i2s_state_t;

  // One frame spans two slots; each bclk period is two half-periods of bclk_div clks.
  function automatic int unsigned i2s_frame_clks(input int unsigned slot_bits,
                                                 input int unsigned bclk_div);
    return 4 * slot_bits * bclk_div;
  endfunction

endpackage

// File: rtl/i2s_tx_if.sv
// Sample-stream input and I2S bus output of the mono I2S transmitter.
// Signals:
//   data_i, vld_i                  - strobed sample stream from the effect chain
//   bclk, lrclk, sdata             - I2S bus to the DAC
//   underrun, overrun              - one-cycle status pulses
// Modports: master = chain/DAC side, slave = transmitter.
interface i2s_tx_if #(
  parameter int unsigned DATA_WIDTH = 8
);

  logic [DATA_WIDTH-1:0] data_i;
  logic                  vld_i;
  logic                  bclk;
  logic                  lrclk;
  logic                  sdata;
  logic                  underrun;
  logic                  overrun;

  modport master (
    output data_i, vld_i,
    input  bclk, lrclk, sdata, underrun, overrun
  );

  modport slave (
    input  data_i, vld_i,
    output bclk, lrclk, sdata, underrun, overrun
  );

endinterface

// File: rtl/bclk_gen.sv
// I2S bit-clock generator: divides clk into bclk and flags each falling edge.
// Ports:
//   clk, rst - system clock, synchronous active-high reset
//   en       - run enable; when low the divider and bclk are held at 0
//   bclk     - registered bit clock, half-period BCLK_DIV clks
//   fall_c   - combinational strobe: bclk goes 1->0 at the next clk edge
module bclk_gen #(
  parameter int unsigned BCLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic bclk,
  output logic fall_c
);

  localparam int unsigned    DIV_W    = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

  logic [DIV_W-1:0] div;
  logic             wrap_c;

  assign wrap_c = (div == DIV_LAST);

  // Half-period divider; bclk toggles when it wraps.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      div  <= '0;
      bclk <= 1'b0;
    end else if (wrap_c) begin
      div  <= '0;
      bclk <= ~bclk;
    end else begin
      div  <= div + DIV_W'(1);
    end
  end

  assign fall_c = en && wrap_c && bclk;

endmodule

// File: rtl/i2s_tx.sv
// Mono I2S transmitter: holds the latest chain sample and sends it MSB-first
// in both the left and right slot of every frame, with one-bclk I2S delay.
// Ports:
//   clk, rst - system clock, synchronous active-high reset
//   bus      - i2s_tx_if slave: data_i/vld_i in; bclk/lrclk/sdata/underrun/overrun out
module i2s_tx
  import audio_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned SLOT_BITS  = 16,
  parameter int unsigned BCLK_DIV   = 2
) (
  input  logic      clk,
  input  logic      rst,
  i2s_tx_if.slave   bus
);

  localparam int unsigned    FRAME_BITS = 2 * SLOT_BITS;
  localparam int unsigned    P_W        = $clog2(FRAME_BITS);
  localparam logic [P_W-1:0] P_LAST     = P_W'(FRAME_BITS - 1);
  localparam logic [P_W-1:0] SLOT       = P_W'(SLOT_BITS);

  // Elaboration-time parameter checks.
  if (SLOT_BITS <= DATA_WIDTH) begin : g_bad_slot
    $error("i2s_tx: SLOT_BITS must be greater than DATA_WIDTH");
  end
  if (BCLK_DIV < 1) begin : g_bad_div
    $error("i2s_tx: BCLK_DIV must be at least 1");
  end

  i2s_state_t            state, state_next;
  logic [P_W-1:0]        p, p_next;
  logic [DATA_WIDTH-1:0] hold, hold_next;
  logic                  hold_full, hold_full_next;
  logic [DATA_WIDTH-1:0] shreg, shreg_next;
  logic                  lrclk_r, lrclk_next;
  logic                  sdata_r, sdata_next;
  logic                  underrun_r, underrun_next;
  logic                  overrun_r, overrun_next;
  logic [P_W-1:0]        off_c;
  logic                  run_c;
  logic                  fall_c;
  logic                  frame_start_c;

  assign run_c = (state == RUN);

  bclk_gen #(
    .BCLK_DIV (BCLK_DIV)
  ) u_bclk_gen (
    .clk    (clk),
    .rst    (rst),
    .en     (run_c),
    .bclk   (bus.bclk),
    .fall_c (fall_c)
  );

  // The falling edge that wraps p back to 0 starts a new frame.
  assign frame_start_c = fall_c && (p == P_LAST);

  // Next-state, frame position, holding register and output logic.
  always_comb begin
    state_next     = state;
    p_next         = p;
    hold_next      = hold;
    hold_full_next = hold_full;
    shreg_next     = shreg;
    underrun_next  = 1'b0;
    overrun_next   = 1'b0;
    lrclk_next     = 1'b0;
    sdata_next     = 1'b0;
    off_c          = '0;

    case (state)
      IDLE: begin
        if (bus.vld_i) begin
          // The entry frame consumes the triggering sample directly.
          state_next = RUN;
          p_next     = '0;
          hold_next  = bus.data_i;
          shreg_next = bus.data_i;
        end
      end
      RUN: begin
        if (fall_c) begin
          p_next = (p == P_LAST) ? '0 : p + P_W'(1);
        end
        if (frame_start_c) begin
          if (hold_full) begin
            shreg_next     = hold;
            hold_full_next = 1'b0;
          end else begin
            underrun_next = 1'b1;
          end
        end else if (bus.vld_i && hold_full) begin
          overrun_next = 1'b1;
        end
        // A sample arriving on a frame-start load refills hold without overrun.
        if (bus.vld_i) begin
          hold_next      = bus.data_i;
          hold_full_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    // Slot offset 0 is the I2S delay bit; bits 1..DATA_WIDTH carry MSB..LSB.
    lrclk_next = (p_next >= SLOT);
    off_c      = lrclk_next ? (p_next - SLOT) : p_next;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (off_c == P_W'(DATA_WIDTH - i)) begin
        sdata_next = shreg[i];
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      p          <= '0;
      hold       <= '0;
      hold_full  <= 1'b0;
      shreg      <= '0;
      lrclk_r    <= 1'b0;
      sdata_r    <= 1'b0;
      underrun_r <= 1'b0;
      overrun_r  <= 1'b0;
    end else begin
      state      <= state_next;
      p          <= p_next;
      hold       <= hold_next;
      hold_full  <= hold_full_next;
      shreg      <= shreg_next;
      lrclk_r    <= lrclk_next;
      sdata_r    <= sdata_next;
      underrun_r <= underrun_next;
      overrun_r  <= overrun_next;
    end
  end

  assign bus.lrclk    = lrclk_r;
  assign bus.sdata    = sdata_r;
  assign bus.underrun = underrun_r;
  assign bus.overrun  = overrun_r;

endmodule

// File: tb/tb_i2s_tx.sv
// Self-checking bench for i2s_tx: time-based behavioural model compared every
// cycle, plus literal expectations for entry latency, bit pattern and flags.
module tb_i2s_tx;
  import audio_pkg::*;

  localparam int unsigned DW    = 8;
  localparam int unsigned S     = 16;
  localparam int unsigned D     = 2;
  localparam int unsigned FRAME = i2s_frame_clks(S, D);

  logic clk = 1'b0;
  logic rst = 1'b1;

  i2s_tx_if #(.DATA_WIDTH(DW)) bus ();

  i2s_tx #(
    .DATA_WIDTH (DW),
    .SLOT_BITS  (S),
    .BCLK_DIV   (D)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_print = 0;

  // Model: cycles since entry (k) determine all bus timing arithmetically.
  bit          m_run = 1'b0;
  int unsigned m_k = 0;
  logic [7:0]  m_hold = '0;
  logic [7:0]  m_cur = '0;
  bit          m_full = 1'b0;
  bit          m_under = 1'b0;
  bit          m_over = 1'b0;

  // Monitor state fed from DUT outputs.
  int          under_cnt = 0;
  int          over_cnt = 0;
  int          toggles = 0;
  logic        prev_bclk = 1'b0;
  logic [7:0]  dec = '0;
  logic [7:0]  last_left = '0;
  logic [7:0]  last_right = '0;

  function automatic logic [4:0] model_out();
    int unsigned p, o;
    logic b, l, s;
    if (!m_run) return 5'b0;
    b = ((m_k / D) % 2) == 1;
    p = (m_k / (2 * D)) % (2 * S);
    l = (p >= S);
    o = p % S;
    s = (o >= 1 && o <= DW) ? m_cur[DW - o] : 1'b0;
    return {b, l, s, m_under, m_over};
  endfunction

  // Inputs only change at negedge+2, so at negedge they still hold the values
  // sampled at the preceding posedge: advance the model, then compare.
  initial begin
    logic [4:0] act, exp;
    int unsigned dp, dop;
    forever begin
      @(negedge clk);
      m_under = 1'b0;
      m_over  = 1'b0;
      if (rst) begin
        m_run = 1'b0; m_k = 0; m_full = 1'b0; m_cur = '0; m_hold = '0;
      end else if (!m_run) begin
        if (bus.vld_i) begin
          m_run = 1'b1; m_k = 0; m_cur = bus.data_i; m_hold = bus.data_i; m_full = 1'b0;
        end
      end else begin
        m_k++;
        if ((m_k % FRAME) == 0) begin
          if (m_full) begin
            m_cur = m_hold; m_full = 1'b0;
          end else begin
            m_under = 1'b1;
          end
        end else if (bus.vld_i && m_full) begin
          m_over = 1'b1;
        end
        if (bus.vld_i) begin
          m_hold = bus.data_i; m_full = 1'b1;
        end
      end

      act = {bus.bclk, bus.lrclk, bus.sdata, bus.underrun, bus.overrun};
      exp = model_out();
      n_cmp++;
      if (act !== exp) begin
        n_err++;
        if (n_print < 20) begin
          n_print++;
          $display("FAIL per_cycle t=%0t k=%0d run=%0d got=%b want=%b (bclk,lrclk,sdata,underrun,overrun)",
                   $time, m_k, m_run, act, exp);
        end
      end

      under_cnt += int'(bus.underrun);
      over_cnt  += int'(bus.overrun);
      if (bus.bclk !== prev_bclk) toggles++;
      prev_bclk = bus.bclk;

      if (m_run && (m_k % (2 * D)) == 0) begin
        dp  = (m_k / (2 * D)) % (2 * S);
        dop = dp % S;
        if (dop >= 1 && dop <= DW) begin
          dec = {dec[DW-2:0], bus.sdata};
          if (dop == DW) begin
            if (dp < S) last_left = dec;
            else        last_right = dec;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  // Advance until the cycle whose frame offset (k mod FRAME) equals target.
  task automatic wait_k(input int unsigned target);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < int'(2 * FRAME); i++) begin
      if (!hit) begin
        step();
        hit = m_run && ((m_k % FRAME) == target);
      end
    end
    if (!hit) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_k timeout: got no match want offset %0d", target);
    end
  endtask

  // Single sample from IDLE, then check the entry latency points.
  task automatic check_entry(input logic [7:0] b);
    bus.vld_i  = 1'b1;
    bus.data_i = b;
    step();
    bus.vld_i = 1'b0;
    chk("entry_c1_bclk_lr_sd", {29'd0, bus.bclk, bus.lrclk, bus.sdata}, 32'd0);
    step(); step();
    chk("entry_bclk_rise", {31'd0, bus.bclk}, 32'd1);
    step(); step();
    chk("entry_first_fall_msb", {30'd0, bus.bclk, bus.sdata}, {30'd0, 1'b0, b[7]});
  endtask

  initial begin
    bus.vld_i  = 1'b0;
    bus.data_i = '0;
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;

    // Idle after reset: nothing moves.
    toggles = 0;
    repeat (200) step();
    chk("idle_no_toggle", toggles, 0);
    chk("idle_outputs", {27'd0, bus.bclk, bus.lrclk, bus.sdata, bus.underrun, bus.overrun}, 32'd0);

    // Single A5, then free-running repeats with underruns.
    check_entry(8'hA5);
    toggles = 0;
    under_cnt = 0;
    repeat (128) step();
    chk("frame_bclk_toggles", toggles, 64);
    chk("a5_left", last_left, 8'hA5);
    chk("a5_right", last_right, 8'hA5);
    repeat (368) step();
    chk("underrun_per_frame", under_cnt, 3);
    chk("a5_repeat_left", last_left, 8'hA5);

    // Two samples within one frame: one overrun, the later one wins.
    wait_k(20);
    over_cnt = 0;
    under_cnt = 0;
    bus.vld_i = 1'b1; bus.data_i = 8'h11;
    step();
    bus.vld_i = 1'b0;
    repeat (9) step();
    bus.vld_i = 1'b1; bus.data_i = 8'h22;
    step();
    bus.vld_i = 1'b0;
    wait_k(100);
    wait_k(40);
    chk("overrun_count", over_cnt, 1);
    chk("overrun_winner", last_left, 8'h22);
    chk("overrun_no_underrun", under_cnt, 0);

    // Sample on the exact frame-start cycle with 44 pending.
    over_cnt = 0;
    under_cnt = 0;
    wait_k(50);
    bus.vld_i = 1'b1; bus.data_i = 8'h44;
    step();
    bus.vld_i = 1'b0;
    wait_k(FRAME - 1);
    bus.vld_i = 1'b1; bus.data_i = 8'h33;
    step();
    bus.vld_i = 1'b0;
    wait_k(40);
    chk("fs_frame_old_hold", last_left, 8'h44);
    wait_k(100);
    wait_k(40);
    chk("fs_next_frame_new", last_left, 8'h33);
    chk("fs_no_overrun", over_cnt, 0);
    chk("fs_no_underrun", under_cnt, 0);

    // Reset at p = 20, then restart.
    wait_k(81);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midframe_rst_outputs", {27'd0, bus.bclk, bus.lrclk, bus.sdata, bus.underrun, bus.overrun}, 32'd0);
    toggles = 0;
    repeat (5) step();
    chk("post_rst_idle", toggles, 0);
    check_entry(8'hC3);
    repeat (40) step();
    chk("restart_left", last_left, 8'hC3);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 4000; i++) begin
      bus.vld_i  = ($urandom_range(0, 59) == 0);
      bus.data_i = 8'($urandom);
      rst        = ($urandom_range(0, 1999) == 0);
      step();
    end
    bus.vld_i = 1'b0;
    rst = 1'b0;
    repeat (10) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/i2s_tx.md
# i2s_tx

Mono I2S transmitter at the output end of the effect chain. It consumes the chain's valid-strobed sample stream (`data_i`/`vld_i`, the same stream every effect stage produces) and serializes each sample MSB-first onto an I2S bus to the audio DAC. It generates its own bit clock and word-select from `clk`, and duplicates each sample into the left and right slots. A one-entry holding register decouples the chain's sample rate from the bus frame rate, with underrun and overrun flags.

## Interface
- `DATA_WIDTH`, 8, sample width, signed two's complement.
- `SLOT_BITS`, 16, bclk periods per channel slot. Must be at least `DATA_WIDTH+1`.
- `BCLK_DIV`, 2, clk cycles per bclk half-period. Must be at least 1.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-high.
- `data_i`  in  `DATA_WIDTH`  sample from the effect chain.
- `vld_i`  in  1  one-cycle strobe; `data_i` is valid this cycle. No backpressure.
- `bclk`  out  1  I2S bit clock, registered.
- `lrclk`  out  1  I2S word select, registered; 0 = left slot, 1 = right slot.
- `sdata`  out  1  I2S serial data, registered; changes only on bclk falling edges.
- `underrun`  out  1  one-cycle pulse: a frame started with no new sample pending.
- `overrun`  out  1  one-cycle pulse: a sample overwrote an unconsumed pending sample.

## Operation
- FSM states:
  - IDLE: reset state. `bclk`, `lrclk`, `sdata`, `underrun` and `overrun` are all 0.
  - RUN: entered on the first `vld_i`. Left only by `rst`.
- Holding register `hold` with flag `hold_full`. On `vld_i`: `hold <= data_i` and `hold_full <= 1`.
- In RUN:
  - Divider `div` counts 0..`BCLK_DIV`-1. When `div == BCLK_DIV-1`: `div <= 0` and `bclk` toggles.
  - A toggle from 1 to 0 is a falling-edge event. Each falling edge advances frame position `p` by one: 0..2·`SLOT_BITS`-1, wrapping to 0.
- Output at position `p`, with slot offset `o = p mod SLOT_BITS`:
  - `lrclk = (p >= SLOT_BITS)`.
  - `sdata = shreg[DATA_WIDTH-o]` for `o` in 1..`DATA_WIDTH`, else 0. This is the standard I2S one-bit delay: the MSB appears one bclk after the lrclk edge.
- Frame start means `p` becomes 0, including on entry to RUN.
  - If `hold_full`: `shreg <= hold`, `hold_full <= 0`.
  - Else: `shreg` keeps its previous sample and `underrun` pulses. A sample is therefore repeated, never replaced by silence.
  - The entry frame always loads, because the triggering sample is already in `hold`.
- Both slots of a frame transmit the same `shreg` value. `shreg` is not shifted; bits are indexed by `o`.
- `vld_i` on the same cycle as a frame-start load: the old `hold` goes to `shreg`, the new sample goes into `hold`, `hold_full` stays 1, and there is no overrun.
- `vld_i` while `hold_full` and not a frame-start cycle: `hold` is overwritten and `overrun` pulses.
- `vld_i` in IDLE with `rst` low: `hold` is captured and the state is RUN next cycle.

## Timing
- Reset values: `bclk = lrclk = sdata = underrun = overrun = 0`, `div = 0`, `p = 0`, `hold_full = 0`, `shreg = 0`, state IDLE.
- `rst` mid-frame: all outputs are 0 on the next cycle, the pending sample is discarded, and the state is IDLE.
- bclk period is 2·`BCLK_DIV` clk. Frame length is 4·`SLOT_BITS`·`BCLK_DIV` clk; 128 clk at defaults.
- Entry latency:
  - Cycle 0: `vld_i` in IDLE.
  - Cycle 1: RUN, `p = 0`, `bclk = 0`, `lrclk = 0`, `sdata = 0`.
  - Cycle 1 + `BCLK_DIV`: `bclk` rises.
  - Cycle 1 + 2·`BCLK_DIV`: first falling edge, `p = 1`, `sdata` = MSB.
- `lrclk` and `sdata` update in the same cycle as a `bclk` 1→0 transition. They are stable across every rising edge.
- `underrun` and `overrun` are asserted for exactly one clk, in the cycle after the triggering condition.

## Structure
- `audio_pkg` holds:
  - state typedef `i2s_state_t` {IDLE, RUN};
  - function `i2s_frame_clks(slot_bits, bclk_div)` returning the frame length, shared with the bench.
- Sub-module `bclk_gen`: owns `div`, the `bclk` register and the falling-edge strobe; enabled by RUN.
- Top level owns the FSM, `p`, holding register, `shreg` and the flags.
- Parameter checks are elaboration-time assertions: `SLOT_BITS > DATA_WIDTH`, `BCLK_DIV >= 1`.

## Test plan
All scenarios use defaults: `DATA_WIDTH` 8, `SLOT_BITS` 16, `BCLK_DIV` 2.
- Reset, then 200 clk with no `vld_i` -> all outputs stay 0 and `bclk` never toggles.
- One `vld_i` with `8'hA5` -> `bclk` period is 4 clk. Left slot `p` = 0..15 carries `sdata` 0,1,0,1,0,0,1,0,1 then zeros. `lrclk` rises at `p = 16`, and the right slot repeats the same bit pattern.
- No further `vld_i` after `8'hA5` -> `underrun` pulses once at every frame start (every 128 clk), and each frame re-sends `8'hA5`.
- `vld_i` with `8'h11`, then `8'h22`, both within one frame, neither on a frame-start cycle -> one `overrun` pulse, and the next frame transmits `8'h22`.
- `vld_i` with `8'h33` on the exact frame-start cycle while `hold = 8'h44` -> this frame sends `8'h44`, the next sends `8'h33`, and no `overrun`.
- `rst` asserted at `p = 20`, one cycle -> next cycle all outputs are 0 and the state is IDLE. A new `vld_i` restarts the sequence with the entry latency above.
